lsu_subword: RTL and testbench

- Load/store unit between the CPU datapath and the word-only data memory.
- Memory only reads and writes full aligned 32-bit words, so this block turns CPU byte, halfword and word accesses into word accesses.
- Sub-word stores are done as read-modify-write. Loads are lane-extracted and then sign- or zero-extended.
- Raises busy so the CPU stalls for the duration of each multi-cycle access.

---
 rtl/lsu_subword.sv | 168 ++++++++++++++++
 tb/tb_lsu_subword.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/lsu_subword.sv
// lsu_subword: turns CPU byte/half/word loads and stores into aligned word
// accesses on a word-only data memory; sub-word stores are read-modify-write.
// Ports: clk, rstn (async active-low)
//   CPU side : req, we, size, sign_ext, addr, wdata -> rdata, busy, done, err
//   Mem side : mem_we, mem_addr, mem_din -> memory; mem_dout <- memory (1-cycle read)
module lsu_subword #(
  parameter int MEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_din,
  input  logic [31:0] mem_dout
);

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  // Completion is not a held state: done/err are registered on the
  // way back to IDLE, so a new request can land in the done cycle.
  typedef enum logic [1:0] {
    IDLE,
    RD,
    EXT,
    WR
  } state_t;

  state_t      state_q, state_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        sx_q, sx_d;
  logic [1:0]  off_q, off_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] maddr_q, maddr_d;
  logic [31:0] rdata_q, rdata_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic        bad;
  logic [4:0]  sh_b;
  logic [4:0]  sh_h;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] ld_ext;
  logic [31:0] mask;
  logic [31:0] ins;
  logic [31:0] merged;

  assign bad = (size == 2'b11)
             | ((size == SZ_H) & addr[0])
             | ((size == SZ_W) & (|addr[1:0]))
             | (addr[31:2] >= 30'(MEM_WORDS));

  assign sh_b   = {off_q, 3'b000};
  assign sh_h   = {off_q[1], 4'b0000};
  assign byte_v = 8'(mem_dout >> sh_b);
  assign half_v = off_q[1] ? mem_dout[31:16] : mem_dout[15:0];

  always_comb begin
    ld_ext = mem_dout;
    unique case (1'b1)
      (size_q == SZ_B): ld_ext = {{24{sx_q & byte_v[7]}}, byte_v};
      (size_q == SZ_H): ld_ext = {{16{sx_q & half_v[15]}}, half_v};
      default:          ld_ext = mem_dout;
    endcase
  end

  // Lane replace for RMW stores: old word from memory, new lane from CPU.
  always_comb begin
    if (size_q == SZ_B) begin
      mask = 32'h0000_00ff << sh_b;
      ins  = {24'd0, wdata_q[7:0]} << sh_b;
    end else begin
      mask = 32'h0000_ffff << sh_h;
      ins  = {16'd0, wdata_q[15:0]} << sh_h;
    end
    merged = (mem_dout & ~mask) | (ins & mask);
  end

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    size_d  = size_q;
    sx_d    = sx_q;
    off_d   = off_q;
    wdata_d = wdata_q;
    maddr_d = maddr_q;
    rdata_d = rdata_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          we_d    = we;
          size_d  = size;
          sx_d    = sign_ext;
          off_d   = addr[1:0];
          wdata_d = wdata;
          if (bad) begin
            done_d = 1'b1;
            err_d  = 1'b1;
          end else begin
            maddr_d = {addr[31:2], 2'b00};
            state_d = (we && size == SZ_W) ? WR : RD;
          end
        end
      end
      RD: state_d = we_q ? WR : EXT;
      EXT: begin
        rdata_d = ld_ext;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      WR: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      sx_q    <= 1'b0;
      off_q   <= 2'b00;
      wdata_q <= '0;
      maddr_q <= '0;
      rdata_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      sx_q    <= sx_d;
      off_q   <= off_d;
      wdata_q <= wdata_d;
      maddr_q <= maddr_d;
      rdata_q <= rdata_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign rdata    = rdata_q;
  assign done     = done_q;
  assign err      = err_q;
  assign busy     = (state_q != IDLE);
  assign mem_we   = (state_q == WR);
  assign mem_addr = maddr_q;
  assign mem_din  = (state_q != WR) ? 32'd0
                  : (size_q == SZ_W) ? wdata_q : merged;

endmodule

// File: tb/tb_lsu_subword.sv
// tb_lsu_subword: directed table-driven bench for lsu_subword with a
// behavioural word memory (1-cycle read latency).
module tb_lsu_subword;

  logic        clk = 1'b0;
  logic        rstn;
  logic        req;
  logic        we;
  logic [1:0]  size;
  logic        sign_ext;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        busy;
  logic        done;
  logic        err;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_din;
  logic [31:0] mem_dout;

  int tests = 0;
  int failed = 0;

  logic [31:0] mem [64];

  always #5 clk = ~clk;

  lsu_subword #(.MEM_WORDS(64)) dut (
    .clk(clk), .rstn(rstn), .req(req), .we(we), .size(size),
    .sign_ext(sign_ext), .addr(addr), .wdata(wdata), .rdata(rdata),
    .busy(busy), .done(done), .err(err), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
  );

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[7:2]] <= mem_din;
    mem_dout <= mem[mem_addr[7:2]];
  end

  typedef struct {
    logic        we;
    logic [1:0]  sz;
    logic        sx;
    logic [31:0] a;
    logic [31:0] wd;
    int          lat;
    logic        er;
    logic [31:0] rd;
    int          nwe;
    logic [31:0] din;
  } vec_t;

  vec_t tv[16];

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic run(input vec_t t, input string nm);
    int lat;
    int nwe;
    logic e;
    logic [31:0] din;
    bit got;
    @(negedge clk);
    req = 1'b1; we = t.we; size = t.sz; sign_ext = t.sx;
    addr = t.a; wdata = t.wd;
    @(posedge clk);
    #1 req = 1'b0;
    lat = 0; nwe = 0; e = 1'b0; din = 32'd0; got = 0;
    for (int k = 1; k <= 10 && !got; k++) begin
      @(negedge clk);
      if (mem_we) begin
        nwe++;
        din = mem_din;
      end
      if (done) begin
        got = 1;
        lat = k;
        e = err;
      end
    end
    chk({nm, " latency"}, 32'(lat), 32'(t.lat));
    chk({nm, " err"}, {31'd0, e}, {31'd0, t.er});
    chk({nm, " rdata"}, rdata, t.rd);
    chk({nm, " mem_we count"}, 32'(nwe), 32'(t.nwe));
    if (t.nwe != 0) chk({nm, " mem_din"}, din, t.din);
  endtask

  initial begin
    int ndone;
    int nwe;
    int nbusy;
    foreach (mem[i]) mem[i] = 32'd0;
    mem_dout = 32'd0;
    req = 0; we = 0; size = 0; sign_ext = 0; addr = 0; wdata = 0;

    //         we    sz     sx    addr       wdata        lat er  rdata        nwe din
    tv[0]  = '{1'b1, 2'd2, 1'b0, 32'h08, 32'hDEADBEEF, 2, 1'b0, 32'h00000000, 1, 32'hDEADBEEF};
    tv[1]  = '{1'b0, 2'd2, 1'b0, 32'h08, 32'h0,        3, 1'b0, 32'hDEADBEEF, 0, 32'h0};
    tv[2]  = '{1'b1, 2'd0, 1'b0, 32'h09, 32'h55,       3, 1'b0, 32'hDEADBEEF, 1, 32'hDEAD55EF};
    tv[3]  = '{1'b0, 2'd0, 1'b1, 32'h0B, 32'h0,        3, 1'b0, 32'hFFFFFFDE, 0, 32'h0};
    tv[4]  = '{1'b0, 2'd0, 1'b0, 32'h0B, 32'h0,        3, 1'b0, 32'h000000DE, 0, 32'h0};
    tv[5]  = '{1'b1, 2'd1, 1'b0, 32'h0A, 32'h8001,     3, 1'b0, 32'h000000DE, 1, 32'h800155EF};
    tv[6]  = '{1'b0, 2'd1, 1'b1, 32'h0A, 32'h0,        3, 1'b0, 32'hFFFF8001, 0, 32'h0};
    tv[7]  = '{1'b0, 2'd1, 1'b0, 32'h08, 32'h0,        3, 1'b0, 32'h000055EF, 0, 32'h0};
    tv[8]  = '{1'b1, 2'd1, 1'b0, 32'h03, 32'h1234,     1, 1'b1, 32'h000055EF, 0, 32'h0};
    tv[9]  = '{1'b1, 2'd2, 1'b0, 32'h06, 32'h1234,     1, 1'b1, 32'h000055EF, 0, 32'h0};
    tv[10] = '{1'b0, 2'd3, 1'b0, 32'h08, 32'h0,        1, 1'b1, 32'h000055EF, 0, 32'h0};
    tv[11] = '{1'b1, 2'd2, 1'b0, 32'h100, 32'h1234,    1, 1'b1, 32'h000055EF, 0, 32'h0};
    tv[12] = '{1'b0, 2'd0, 1'b1, 32'h08, 32'h0,        3, 1'b0, 32'hFFFFFFEF, 0, 32'h0};
    tv[13] = '{1'b1, 2'd0, 1'b0, 32'h0C, 32'h123456AB, 3, 1'b0, 32'hFFFFFFEF, 1, 32'h000000AB};
    tv[14] = '{1'b1, 2'd1, 1'b0, 32'h0E, 32'hFFFF1234, 3, 1'b0, 32'hFFFFFFEF, 1, 32'h123400AB};
    tv[15] = '{1'b0, 2'd2, 1'b0, 32'h0C, 32'h0,        3, 1'b0, 32'h123400AB, 0, 32'h0};

    rstn = 1'b0;
    #1;
    chk("reset rdata", rdata, 32'd0);
    chk("reset done", {31'd0, done}, 32'd0);
    chk("reset err", {31'd0, err}, 32'd0);
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset mem_we", {31'd0, mem_we}, 32'd0);
    chk("reset mem_addr", mem_addr, 32'd0);
    chk("reset mem_din", mem_din, 32'd0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;

    for (int i = 0; i < 16; i++) run(tv[i], $sformatf("vec%0d", i));

    // Abort a byte store at 0x10 by resetting during its RD cycle.
    @(negedge clk);
    req = 1'b1; we = 1'b1; size = 2'd0; sign_ext = 1'b0;
    addr = 32'h10; wdata = 32'h77;
    @(posedge clk);
    #1 req = 1'b0;
    @(negedge clk);
    chk("rmw busy in RD", {31'd0, busy}, 32'd1);
    rstn = 1'b0;
    #1;
    chk("async rst busy", {31'd0, busy}, 32'd0);
    chk("async rst mem_we", {31'd0, mem_we}, 32'd0);
    chk("async rst rdata", rdata, 32'd0);
    chk("async rst mem_addr", mem_addr, 32'd0);
    nwe = 0;
    repeat (2) begin
      @(negedge clk);
      if (mem_we) nwe++;
    end
    rstn = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (mem_we) nwe++;
    end
    chk("aborted store mem_we", 32'(nwe), 32'd0);
    chk("aborted store word", mem[4], 32'd0);
    run('{1'b0, 2'd2, 1'b0, 32'h08, 32'h0, 3, 1'b0, 32'h800155EF, 0, 32'h0},
        "post-reset load");

    // req held high: word stores every two cycles, one done per accept.
    @(negedge clk);
    req = 1'b1; we = 1'b1; size = 2'd2; sign_ext = 1'b0;
    addr = 32'h14; wdata = 32'hCAFEF00D;
    ndone = 0; nwe = 0; nbusy = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (done) ndone++;
      if (mem_we) nwe++;
      if (busy) nbusy++;
    end
    req = 1'b0;
    chk("b2b done count", 32'(ndone), 32'd5);
    chk("b2b mem_we count", 32'(nwe), 32'd5);
    chk("b2b busy cycles", 32'(nbusy), 32'd5);
    repeat (3) @(negedge clk);
    chk("b2b stored word", mem[5], 32'hCAFEF00D);

    // req held high on loads: period of three cycles.
    @(negedge clk);
    req = 1'b1; we = 1'b0; size = 2'd2; addr = 32'h14;
    ndone = 0; nwe = 0;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (done) ndone++;
      if (mem_we) nwe++;
    end
    req = 1'b0;
    chk("b2b load done count", 32'(ndone), 32'd3);
    chk("b2b load mem_we count", 32'(nwe), 32'd0);
    chk("b2b load rdata", rdata, 32'hCAFEF00D);
    repeat (4) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
